// File: rtl/core_inst_req_slice_pkg.sv
// Shared types and helpers for the instruction-side OBI request slice.
//   OUTST_W    : width of the outstanding-fetch counter
//   outst_t    : outstanding-fetch counter type
//   outst_next : counter update for one increment and one decrement source
package core_inst_req_slice_pkg;

  localparam int OUTST_W = 3;

  typedef logic [OUTST_W-1:0] outst_t;

  // Simultaneous increment and decrement cancel out. Callers guarantee the
  // counter never wraps: increments are gated by the outstanding limit and
  // decrements only happen for responses that are actually owed.
  function automatic outst_t outst_next(input outst_t cnt, input logic inc, input logic dec);
    outst_t res;
    res = cnt;
    if (inc && !dec) begin
      res = cnt + outst_t'(1);
    end else if (dec && !inc) begin
      res = cnt - outst_t'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/core_inst_req_slice_obi_req_register.sv
// Single-entry valid + payload register.
// It is used for the fetch request toward the decoder and for the
// registered response toward the core.
//   clk_i    in   clock
//   reset_i  in   asynchronous active-high reset
//   load_i   in   capture data_i and set valid (has priority over clear_i)
//   clear_i  in   drop valid when no load happens this cycle
//   data_i   in   WIDTH payload to capture
//   valid_o  out  entry holds a payload
//   data_o   out  WIDTH stored payload (changes only on load)
module obi_req_register #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples values from before the clock edge, whatever the block order.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      valid_o <= 1'b0;
    end else if (load_i) begin
      valid_o <= 1'b1;
    end else if (clear_i) begin
      valid_o <= 1'b0;
    end
  end

  // NOTE: the payload is a single register that drives module outputs
  // directly, so it is reset to zero. The outputs are then 0 during reset
  // instead of holding the last address or data.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_o <= '0;
    end else if (load_i) begin
      data_o <= data_i;
    end
  end

endmodule

// File: rtl/core_inst_req_slice.sv
// Registered OBI request/response slice between the core instruction port
// and the instruction-side decoder (ROM / instruction SRAM).
// The fetch request is registered toward the decoder.
// Accepted-but-unanswered fetches are counted and capped at MAX_OUTSTANDING.
// The response path is either registered (RESP_REG=1) or a pass-through.
// Downstream returns responses in request order.
//   clk_i / reset_i                 clock, asynchronous active-high reset
//   core_req_i, core_addr_i         core fetch request and address
//   core_gnt_o                      core request accepted this cycle
//   core_rvalid_o, core_rdata_o     fetch response toward the core
//   mem_req_o, mem_addr_o           registered request toward the decoder
//   mem_gnt_i                       decoder grant
//   mem_rvalid_i, mem_rdata_i       decoder response
//   outstanding_o                   current outstanding-fetch count
//   unexp_rvalid_o                  sticky: response arrived with nothing owed
module core_inst_req_slice
  import core_inst_req_slice_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter bit RESP_REG        = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  core_req_i,
  input  logic [ADDR_WIDTH-1:0] core_addr_i,
  output logic                  core_gnt_o,
  output logic                  core_rvalid_o,
  output logic [DATA_WIDTH-1:0] core_rdata_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [OUTST_W-1:0]    outstanding_o,
  output logic                  unexp_rvalid_o
);

  localparam outst_t MAX_CNT = outst_t'(MAX_OUTSTANDING);

  logic   req_valid;
  logic   core_hs;
  logic   mem_hs;
  outst_t count;
  outst_t owed;
  logic   unexp_now;
  logic   resp_accept;
  logic   unexp_q;

  // ---------------------------------------------------------------------------
  // Request side
  // ---------------------------------------------------------------------------
  assign mem_hs = req_valid & mem_gnt_i;

  // A new fetch is accepted only when the register is free or drains this
  // cycle, and the outstanding limit still has room. The grant is also held
  // low during reset so that every output reads 0 while reset is asserted.
  assign core_hs    = core_req_i & (~req_valid | mem_gnt_i) & (count < MAX_CNT) & ~reset_i;
  assign core_gnt_o = core_hs;

  // A load that coincides with the mem handshake replaces the address and
  // keeps the entry valid, because load has priority over clear.
  obi_req_register #(
    .WIDTH (ADDR_WIDTH)
  ) u_req_reg (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (core_hs),
    .clear_i (mem_hs),
    .data_i  (core_addr_i),
    .valid_o (req_valid),
    .data_o  (mem_addr_o)
  );

  assign mem_req_o = req_valid;

  // ---------------------------------------------------------------------------
  // Outstanding count: +1 per accepted fetch, -1 per response to the core
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count <= '0;
    end else begin
      count <= outst_next(count, core_hs, core_rvalid_o);
    end
  end

  assign outstanding_o = count;

  // ---------------------------------------------------------------------------
  // Response side
  // ---------------------------------------------------------------------------
  // A response is legal only while the decoder still owes one. In the
  // registered mode, a response already sitting in the output register is
  // still counted but no longer owed by the decoder. The count is taken
  // before this cycle's increment, since a fetch granted now cannot be
  // answered in the same cycle.
  assign unexp_now   = mem_rvalid_i & (owed == '0);
  assign resp_accept = mem_rvalid_i & ~unexp_now;

  if (RESP_REG) begin : g_resp_reg
    logic rsp_valid;

    obi_req_register #(
      .WIDTH (DATA_WIDTH)
    ) u_rsp_reg (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .load_i  (resp_accept),
      .clear_i (1'b1),
      .data_i  (mem_rdata_i),
      .valid_o (rsp_valid),
      .data_o  (core_rdata_o)
    );

    assign core_rvalid_o = rsp_valid;
    assign owed          = count - outst_t'(rsp_valid);
  end else begin : g_resp_pass
    assign core_rvalid_o = resp_accept & ~reset_i;
    assign core_rdata_o  = reset_i ? '0 : mem_rdata_i;
    assign owed          = count;
  end

  // Sticky error flag; only reset clears it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      unexp_q <= 1'b0;
    end else if (unexp_now) begin
      unexp_q <= 1'b1;
    end
  end

  assign unexp_rvalid_o = unexp_q;

  // ---------------------------------------------------------------------------
  // Protocol checks
  // ---------------------------------------------------------------------------
  a_addr_stable : assert property (@(posedge clk_i) disable iff (reset_i)
    (mem_req_o && !mem_gnt_i) |=> $stable(mem_addr_o));

  a_count_max : assert property (@(posedge clk_i) disable iff (reset_i)
    count <= MAX_CNT);

endmodule
